// File: rtl/mmu_pkg.sv
// Shared types and default memory map for the MMU request front end.
package mmu_pkg;

    // Arbiter sequencing: idle/arbitrate, wait for MMU, pulse CPU response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which CPU port owns the current transaction.
    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    // Default on-chip window: 64 KiB starting at address 0.
    localparam logic [31:0] ONC_BASE_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ONC_SIZE_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/mmu_addr_decode.sv
// Combinational on-chip / off-chip classification of a data address.
module mmu_addr_decode #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] ONC_BASE = '0,
    parameter logic [ADDR_W-1:0] ONC_SIZE = ADDR_W'(32'h0001_0000)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_on_chip
);

    // The offset is taken two bits wider than the address: the top bit flags
    // an address below the base, and the extra magnitude bit lets a region
    // that ends exactly at 2^ADDR_W compare correctly without wrapping.
    localparam logic [ADDR_W+1:0] BASE_X = {2'b00, ONC_BASE};
    localparam logic [ADDR_W:0]   SIZE_X = {1'b0, ONC_SIZE};

    logic [ADDR_W+1:0] w_offset;

    assign w_offset  = {2'b00, i_addr} - BASE_X;
    assign o_on_chip = ~w_offset[ADDR_W+1] && (w_offset[ADDR_W:0] < SIZE_X);

endmodule

// File: rtl/mmu_req_arbiter.sv
// Front end of the MMU controller: round-robin arbitration between the CPU
// fetch and data ports, on/off-chip decode, one-hot MMU request issue,
// response return and a watchdog for a hung MMU.
module mmu_req_arbiter
    import mmu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] ONC_BASE = ADDR_W'(ONC_BASE_DEFAULT),
    parameter logic [ADDR_W-1:0] ONC_SIZE = ADDR_W'(ONC_SIZE_DEFAULT),
    parameter int                TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_resp,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_resp,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              instruction_req,
    output logic              on_c_data_read,
    output logic              on_c_data_write,
    output logic              off_c_data_read,
    output logic              off_c_data_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              mmu_resp,
    input  logic [DATA_W-1:0] mmu_rdata,
    output logic              err
);

    // The counter only needs to reach TIMEOUT-1: the abort fires on the cycle
    // that would have been the TIMEOUT-th increment.
    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    grant_t            r_grant;
    grant_t            r_last_grant;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_inst_req;
    logic              r_onc_rd;
    logic              r_onc_wr;
    logic              r_offc_rd;
    logic              r_offc_wr;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_imem_resp;
    logic [DATA_W-1:0] r_imem_rdata;
    logic              r_dmem_resp;
    logic [DATA_W-1:0] r_dmem_rdata;
    logic              r_err;

    logic              w_inst_pend;
    logic              w_data_pend;
    logic              w_tie;
    logic              w_grant_valid;
    grant_t            w_grant;
    logic              w_on_chip;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic              w_finish;

    mmu_addr_decode #(
        .ADDR_W   (ADDR_W),
        .ONC_BASE (ONC_BASE),
        .ONC_SIZE (ONC_SIZE)
    ) u_addr_decode (
        .i_addr    (dmem_addr),
        .o_on_chip (w_on_chip)
    );

    assign w_inst_pend   = imem_req;
    assign w_data_pend   = dmem_read | dmem_write;
    assign w_tie         = w_inst_pend & w_data_pend;
    assign w_grant_valid = w_inst_pend | w_data_pend;

    assign w_start  = (r_state == IDLE) && w_grant_valid;
    assign w_done   = (r_state == WAIT) && mmu_resp;
    // mmu_resp in the final watchdog cycle still counts as a completion.
    assign w_abort  = (r_state == WAIT) && !mmu_resp && (r_cnt == CNT_LAST);
    assign w_finish = w_done | w_abort;

    // Round-robin pick: a lone requester wins, a tie goes opposite last_grant.
    always_comb begin
        w_grant = GRANT_INST;
        if (w_tie) begin
            if (r_last_grant == GRANT_DATA) begin
                w_grant = GRANT_INST;
            end else begin
                w_grant = GRANT_DATA;
            end
        end else if (w_data_pend) begin
            w_grant = GRANT_DATA;
        end
    end

    // FSM sequencing, round-robin pointer and watchdog count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= GRANT_INST;
            r_last_grant <= GRANT_DATA;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant <= w_grant;
                        if (w_tie) begin
                            r_last_grant <= w_grant;
                        end
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_finish) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // MMU-side request: loaded on grant, held through WAIT, cleared on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_req  <= 1'b0;
            r_onc_rd    <= 1'b0;
            r_onc_wr    <= 1'b0;
            r_offc_rd   <= 1'b0;
            r_offc_wr   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
        end else if (w_start) begin
            // Read and write together resolve to a write.
            r_inst_req  <= (w_grant == GRANT_INST);
            r_onc_rd    <= (w_grant == GRANT_DATA) &&  w_on_chip && !dmem_write;
            r_onc_wr    <= (w_grant == GRANT_DATA) &&  w_on_chip &&  dmem_write;
            r_offc_rd   <= (w_grant == GRANT_DATA) && !w_on_chip && !dmem_write;
            r_offc_wr   <= (w_grant == GRANT_DATA) && !w_on_chip &&  dmem_write;
            r_req_addr  <= (w_grant == GRANT_INST) ? imem_addr : dmem_addr;
            r_req_wdata <= (w_grant == GRANT_INST) ? '0 : dmem_wdata;
        end else if (w_finish) begin
            r_inst_req  <= 1'b0;
            r_onc_rd    <= 1'b0;
            r_onc_wr    <= 1'b0;
            r_offc_rd   <= 1'b0;
            r_offc_wr   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
        end
    end

    // CPU-side response: capture data (or zero on abort), pulse for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_resp  <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_resp  <= 1'b0;
            r_dmem_rdata <= '0;
        end else if (w_finish) begin
            if (r_grant == GRANT_INST) begin
                r_imem_resp  <= 1'b1;
                r_imem_rdata <= w_done ? mmu_rdata : '0;
            end else begin
                r_dmem_resp  <= 1'b1;
                r_dmem_rdata <= w_done ? mmu_rdata : '0;
            end
        end else if (r_state == RESP) begin
            r_imem_resp <= 1'b0;
            r_dmem_resp <= 1'b0;
        end
    end

    // Sticky watchdog flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign instruction_req  = r_inst_req;
    assign on_c_data_read   = r_onc_rd;
    assign on_c_data_write  = r_onc_wr;
    assign off_c_data_read  = r_offc_rd;
    assign off_c_data_write = r_offc_wr;
    assign req_addr         = r_req_addr;
    assign req_wdata        = r_req_wdata;
    assign imem_resp        = r_imem_resp;
    assign imem_rdata       = r_imem_rdata;
    assign dmem_resp        = r_dmem_resp;
    assign dmem_rdata       = r_dmem_rdata;
    assign err              = r_err;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Self-checking bench for mmu_req_arbiter: directed cases plus randomized
// CPU/MMU traffic predicted by a transaction-level reference model.
module tb_mmu_req_arbiter;

    localparam int     AW   = 32;
    localparam int     DW   = 32;
    localparam int     TMO  = 8;
    localparam longint BASE = 64'h0;
    localparam longint SIZE = 64'h1_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_resp;
    logic [DW-1:0] imem_rdata;
    logic          dmem_read;
    logic          dmem_write;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_resp;
    logic [DW-1:0] dmem_rdata;
    logic          instruction_req;
    logic          on_c_data_read;
    logic          on_c_data_write;
    logic          off_c_data_read;
    logic          off_c_data_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          mmu_resp;
    logic [DW-1:0] mmu_rdata;
    logic          err;

    mmu_req_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_resp        (imem_resp),
        .imem_rdata       (imem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .instruction_req  (instruction_req),
        .on_c_data_read   (on_c_data_read),
        .on_c_data_write  (on_c_data_write),
        .off_c_data_read  (off_c_data_read),
        .off_c_data_write (off_c_data_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .mmu_resp         (mmu_resp),
        .mmu_rdata        (mmu_rdata),
        .err              (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          model_last_data;   // last tie winner was the data port
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
    bit          exp_err;
    int          fw;                // clock edges from now until the next grant is visible

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] req_vec();
        return {instruction_req, on_c_data_read, on_c_data_write, off_c_data_read, off_c_data_write};
    endfunction

    function automatic bit in_onchip(input logic [31:0] a);
        longint x;
        x = longint'({32'b0, a});
        return (x >= BASE) && (x < BASE + SIZE);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0:       a = 32'(BASE + SIZE - 4);
            1:       a = 32'(BASE + SIZE);
            2:       a = $urandom & 32'h0000_FFFC;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_req"},   req_vec(), 0);
        check_eq({pfx, "_addr"},  req_addr, 0);
        check_eq({pfx, "_wdata"}, req_wdata, 0);
        check_eq({pfx, "_resp"},  {imem_resp, dmem_resp}, 0);
        check_eq({pfx, "_irdat"}, imem_rdata, 0);
        check_eq({pfx, "_drdat"}, dmem_rdata, 0);
        check_eq({pfx, "_err"},   err, 0);
    endtask

    // One complete transaction starting from the current pending request set.
    task automatic run_txn(input int lat, input logic [31:0] rdata, input bit drop, input bit extra);
        bit          ip, dp, g_data, on;
        logic [4:0]  ev;
        logic [31:0] ea, ew;
        ip = imem_req;
        dp = dmem_read | dmem_write;
        if (ip && dp) begin
            g_data          = !model_last_data;
            model_last_data = g_data;
        end else begin
            g_data = dp;
        end
        if (!g_data) begin
            ev = 5'b10000; ea = imem_addr; ew = 32'h0;
        end else begin
            ea = dmem_addr; ew = dmem_wdata; on = in_onchip(dmem_addr);
            if (dmem_write) ev = on ? 5'b00100 : 5'b00001;
            else            ev = on ? 5'b01000 : 5'b00010;
        end
        for (int k = 1; k < fw; k++) begin
            tick();
            mmu_resp = 1'b0;
            check_eq("gap_req", req_vec(), 0);
            check_eq("gap_resp", {imem_resp, dmem_resp}, 0);
        end
        tick();
        mmu_resp = 1'b0;
        check_eq("grant_vec", req_vec(), ev);
        check_eq("grant_addr", req_addr, ea);
        check_eq("grant_wdata", req_wdata, ew);
        check_eq("grant_err", err, exp_err);
        check_eq("grant_resp", {imem_resp, dmem_resp}, 0);
        if (drop) begin
            if (g_data) begin dmem_read = 1'b0; dmem_write = 1'b0; end
            else        imem_req = 1'b0;
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            check_eq("hold_vec", req_vec(), ev);
            check_eq("hold_addr", req_addr, ea);
            check_eq("hold_resp", {imem_resp, dmem_resp}, 0);
        end
        mmu_resp  = 1'b1;
        mmu_rdata = rdata;
        tick();
        mmu_resp  = extra;
        mmu_rdata = $urandom;
        if (g_data) exp_drdata = rdata;
        else        exp_irdata = rdata;
        check_eq("done_vec", req_vec(), 0);
        check_eq("imem_resp", imem_resp, !g_data);
        check_eq("dmem_resp", dmem_resp, g_data);
        check_eq("imem_rdata", imem_rdata, exp_irdata);
        check_eq("dmem_rdata", dmem_rdata, exp_drdata);
        if (g_data) begin dmem_read = 1'b0; dmem_write = 1'b0; end
        else        imem_req = 1'b0;
        fw = 2;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (imem_req || dmem_read || dmem_write); k++) begin
            run_txn(1, $urandom, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        mmu_resp = 1'b0;
        tick();
        fw = 1;
    endtask

    // At most one MMU request line may be high on any cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) check_eq("onehot", $countones(req_vec()) <= 1, 1);
    end

    initial begin
        rst = 1'b1;
        imem_req = 0; imem_addr = 0;
        dmem_read = 0; dmem_write = 0; dmem_addr = 0; dmem_wdata = 0;
        mmu_resp = 0; mmu_rdata = 0;
        model_last_data = 1'b1;
        exp_irdata = 0; exp_drdata = 0; exp_err = 0; fw = 1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Fetch only.
        imem_req = 1; imem_addr = 32'h0000_1000;
        run_txn(2, 32'h0000_0013, 0, 0);

        // Data decode around the on-chip boundary.
        dmem_read = 1; dmem_addr = 32'h0000_FFFC;
        run_txn(1, $urandom, 0, 0);
        dmem_read = 1; dmem_addr = 32'h0001_0000;
        run_txn(0, $urandom, 0, 0);
        dmem_write = 1; dmem_addr = 32'h8000_0000; dmem_wdata = 32'hCAFE_F00D;
        run_txn(3, $urandom, 0, 0);
        dmem_read = 1; dmem_write = 1; dmem_addr = 32'h0000_0100; dmem_wdata = 32'h1234_5678;
        run_txn(1, $urandom, 0, 0);

        // Contention: both ports held, grants alternate starting with INST.
        for (int n = 0; n < 4; n++) begin
            if (!imem_req) begin imem_req = 1; imem_addr = rand_addr(); end
            if (!dmem_read) begin dmem_read = 1; dmem_addr = rand_addr(); end
            run_txn(1, $urandom, 0, 0);
        end
        drain();
        settle();

        // Stray MMU response while idle is ignored.
        mmu_resp = 1; mmu_rdata = 32'hDEAD_BEEF;
        tick();
        mmu_resp = 0;
        check_eq("stray_req", req_vec(), 0);
        tick();
        check_eq("stray_resp", {imem_resp, dmem_resp}, 0);
        check_eq("stray_irdata", imem_rdata, exp_irdata);
        check_eq("stray_drdata", dmem_rdata, exp_drdata);
        fw = 1;

        // Randomized traffic with varied latency, mid-WAIT drops and stray responses.
        for (int n = 0; n < 150; n++) begin
            if (!imem_req && $urandom_range(0, 1) == 1) begin
                imem_req = 1; imem_addr = rand_addr();
            end
            if (!(dmem_read || dmem_write) && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       begin dmem_read = 1; dmem_write = 0; end
                    1:       begin dmem_read = 0; dmem_write = 1; end
                    default: begin dmem_read = 1; dmem_write = 1; end
                endcase
                dmem_addr = rand_addr(); dmem_wdata = $urandom;
            end
            if (!imem_req && !dmem_read && !dmem_write) begin
                imem_req = 1; imem_addr = rand_addr();
            end
            run_txn($urandom_range(0, 5), $urandom, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0);
        end
        drain();
        settle();

        // Watchdog: MMU never answers a data read.
        dmem_read = 1; dmem_addr = 32'h0000_0200;
        tick();
        check_eq("tmo_first", req_vec(), 5'b01000);
        for (int k = 1; k < TMO; k++) begin
            tick();
            check_eq("tmo_hold", req_vec(), 5'b01000);
            check_eq("tmo_err_low", err, 0);
        end
        tick();
        check_eq("tmo_req", req_vec(), 0);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_dresp", dmem_resp, 1);
        check_eq("tmo_iresp", imem_resp, 0);
        check_eq("tmo_rdata", dmem_rdata, 0);
        exp_drdata = 0; exp_err = 1;
        dmem_read = 0; fw = 2;
        imem_req = 1; imem_addr = 32'h0000_2000;
        run_txn(1, $urandom, 0, 0);
        settle();
        check_eq("err_sticky", err, 1);

        // Reset in the middle of WAIT.
        imem_req = 1; imem_addr = 32'h0000_3000;
        dmem_read = 1; dmem_addr = 32'h0002_0000;
        tick();
        check_eq("rstw_grant", $countones(req_vec()), 1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_all_zero("rst_wait");
        imem_req = 0; dmem_read = 0;
        tick();
        tick();
        check_all_zero("rst_hold");
        rst = 1'b0;
        model_last_data = 1'b1; exp_err = 0; exp_irdata = 0; exp_drdata = 0; fw = 1;
        imem_req = 1; imem_addr = 32'h0000_4000;
        dmem_read = 1; dmem_addr = 32'h0000_0040;
        run_txn(1, $urandom, 0, 0);
        check_eq("post_rst_inst", imem_resp, 1);
        drain();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
